reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
Central reset controller for one clock domain. Synchronizes asynchronous reset sources through internal 2-FF synchronizers and merges them with a synchronous software reset request. Holds all downstream resets asserted until sources are stable, then releases N reset stages one at a time with fixed spacing. Sits at the top level, driving per-subsystem active-high resets.

Parameters:
N_STAGES, 4, number of sequenced reset outputs (1..8); bit 0 released first
HOLD_CYCLES, 16, consecutive request-free cycles required before release begins (1..2^CNT_W-1)
STAGE_DELAY, 8, cycles between successive stage releases (1..2^CNT_W-1)
CNT_W, 8, width of the hold and delay counters

Ports:
clk  in  1  system clock
resetn  in  1  synchronous, active-low controller reset
ext_rst_n  in  1  asynchronous active-low external reset request; 2-FF synchronized internally
pll_locked  in  1  asynchronous lock indicator; 2-FF synchronized internally
sw_rst  in  1  synchronous single-cycle software reset request, active-high
rst_out  out  N_STAGES  active-high stage resets
seq_done  out  1  high when all stages released (state RUN)
rst_cause  out  2  cause of last reset: 0 power-on/resetn, 1 ext, 2 lock loss, 3 sw

Behaviour:
- Reset: one clock, clk; synchronous active-low reset resetn, sampled on the rising edge of clk only.
- While resetn=0: rst_out all 1, seq_done=0, rst_cause=0, state ASSERT, counters and stage index 0, synchronizer flops 0.
- Synchronizers: ext_s and lock_s are 2 flops each; latency 2 edges; no other filtering.
- req = !ext_s | !lock_s | sw_rst.
- FSM states: ASSERT, RELEASE, RUN.
- ASSERT:
  - rst_out all 1; seq_done=0.
  - hold_cnt increments each cycle req=0; clears on any cycle req=1.
  - When hold_cnt reaches HOLD_CYCLES, go to RELEASE: idx=0, dly_cnt=0.
- RELEASE:
  - dly_cnt increments each cycle.
  - When dly_cnt reaches STAGE_DELAY: clear rst_out[idx], idx++, dly_cnt=0.
  - Released bits stay 0; unreleased bits stay 1.
  - The edge that clears rst_out[N_STAGES-1] also enters RUN and sets seq_done=1.
- RUN: rst_out all 0; seq_done=1.
- req=1 in RELEASE or RUN:
  - Next edge: ASSERT, rst_out all 1, seq_done=0, hold_cnt=0.
  - rst_cause updated with priority ext (1) > lock (2) > sw (3).
- req=1 in ASSERT: restarts the hold count only; rst_cause unchanged.
- Timing with defaults, all sources idle at resetn rise (edge 0):
  - rst_out[0] falls at edge 2+16+8=26.
  - Remaining stages fall at edges 34, 42, 50; seq_done rises at edge 50.
- Lock-loss/ext reaction: 3 edges from pin to rst_out assertion. sw_rst reaction: 1 edge.
- Counters saturate, never wrap; idx never exceeds N_STAGES-1.

Optional Feature:
Macro RST_SEQ_ACK_EN.
- Defined:
  - Adds parameter ACK_TIMEOUT (default 255), input stage_ack[N_STAGES-1:0] (synchronous, active-high), and output ack_timeout (sticky, cleared only by resetn).
  - After clearing rst_out[i], the controller waits for stage_ack[i]=1 before counting STAGE_DELAY for stage i+1.
  - For the last stage, entry to RUN waits for stage_ack[N_STAGES-1].
  - If the awaited ack stays low for ACK_TIMEOUT cycles: ack_timeout=1, go to ASSERT, resequence. rst_cause is unchanged.
- Undefined: no extra ports; release is purely delay-based as above.

Test Plan:
- Power-on: resetn low 4 cycles, ext_rst_n=1, pll_locked=1 → rst_out 4'b1111 until edge 26, then 1110@26, 1100@34, 1000@42, 0000@50; seq_done=1@50; rst_cause=0.
- Lock loss in RUN: pll_locked low 1 cycle → rst_out=1111 three edges later, seq_done=0, rst_cause=2, full resequence; rst_out[0] falls 26 edges after lock returns.
- sw_rst pulse in RELEASE with rst_out=1100 → next edge rst_out=1111, rst_cause=3, resequence starts from stage 0.
- ext_rst_n pulsed low every 10 cycles for 200 cycles → state stays ASSERT, rst_out=1111 throughout; release begins 18 cycles after the last pulse.
- ext_rst_n low and sw_rst high on the same cycle in RUN → rst_cause=1.
- RST_SEQ_ACK_EN, ACK_TIMEOUT=20: stage_ack[1] held low, others high → after rst_out[1] clears, 20 cycles later ack_timeout=1 and rst_out=1111. With stage_ack all high, behaviour matches the power-on timing.

Source files
------------

// File: rtl/reset_sequencer.sv
// ============================================================================
// Module   : reset_sequencer
// Purpose  : Synchronizes reset sources and releases N reset stages in order.
//            Optional ack handshake per stage via macro RST_SEQ_ACK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reset_sequencer #(
  parameter int N_STAGES    = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_DELAY = 8,
  parameter int CNT_W       = 8
`ifdef RST_SEQ_ACK_EN
  ,
  parameter int ACK_TIMEOUT = 255
`endif
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                ext_rst_n,
  input  logic                pll_locked,
  input  logic                sw_rst,
`ifdef RST_SEQ_ACK_EN
  input  logic [N_STAGES-1:0] stage_ack,
  output logic                ack_timeout,
`endif
  output logic [N_STAGES-1:0] rst_out,
  output logic                seq_done,
  output logic [1:0]          rst_cause
);

  localparam int c_IDX_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
  localparam logic [c_IDX_W-1:0] c_IDX_LAST  = c_IDX_W'(N_STAGES - 1);
  localparam logic [CNT_W-1:0]   c_HOLD      = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0]   c_DLY_LAST  = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0]   c_CNT_MAX   = '1;
`ifdef RST_SEQ_ACK_EN
  localparam logic [CNT_W-1:0]   c_ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
`endif

  typedef enum logic [1:0] {
    S_ASSERT  = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_ext_meta, r_ext_s, r_lock_meta, r_lock_s;
  logic [CNT_W-1:0]    r_hold, w_hold_nxt;
  logic [CNT_W-1:0]    r_dly, w_dly_nxt;
  logic [c_IDX_W-1:0]  r_idx, w_idx_nxt;
  logic [N_STAGES-1:0] r_rst, w_rst_nxt;
  logic [1:0]          r_cause, w_cause_nxt;
  logic                w_req;
`ifdef RST_SEQ_ACK_EN
  logic                r_acked, w_acked_nxt;
  logic [CNT_W-1:0]    r_ack_cnt, w_ack_cnt_nxt;
  logic                r_ack_to, w_ack_to_nxt;
  logic [c_IDX_W-1:0]  w_prev_idx;
  logic                w_abort_to;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ext_meta  <= 1'b0;
      r_ext_s     <= 1'b0;
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
      r_state     <= S_ASSERT;
      r_hold      <= '0;
      r_dly       <= '0;
      r_idx       <= '0;
      r_rst       <= '1;
      r_cause     <= 2'd0;
`ifdef RST_SEQ_ACK_EN
      r_acked     <= 1'b0;
      r_ack_cnt   <= '0;
      r_ack_to    <= 1'b0;
`endif
    end else begin
      r_ext_meta  <= ext_rst_n;
      r_ext_s     <= r_ext_meta;
      r_lock_meta <= pll_locked;
      r_lock_s    <= r_lock_meta;
      r_state     <= w_state_nxt;
      r_hold      <= w_hold_nxt;
      r_dly       <= w_dly_nxt;
      r_idx       <= w_idx_nxt;
      r_rst       <= w_rst_nxt;
      r_cause     <= w_cause_nxt;
`ifdef RST_SEQ_ACK_EN
      r_acked     <= w_acked_nxt;
      r_ack_cnt   <= w_ack_cnt_nxt;
      r_ack_to    <= w_ack_to_nxt;
`endif
    end
  end

  assign w_req = !r_ext_s | !r_lock_s | sw_rst;

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_dly_nxt   = r_dly;
    w_idx_nxt   = r_idx;
    w_rst_nxt   = r_rst;
    w_cause_nxt = r_cause;
`ifdef RST_SEQ_ACK_EN
    w_acked_nxt   = r_acked;
    w_ack_cnt_nxt = r_ack_cnt;
    w_ack_to_nxt  = r_ack_to;
    w_abort_to    = 1'b0;
    w_prev_idx    = (r_idx == '0) ? '0 : r_idx - c_IDX_W'(1);
`endif
    case (r_state)
      S_ASSERT: begin
        w_rst_nxt = '1;
        if (w_req) begin
          w_hold_nxt = '0;
        end else if (r_hold == c_HOLD) begin
          w_state_nxt = S_RELEASE;
          w_idx_nxt   = '0;
          w_dly_nxt   = '0;
`ifdef RST_SEQ_ACK_EN
          w_acked_nxt   = 1'b1;
          w_ack_cnt_nxt = '0;
`endif
        end else if (r_hold != c_CNT_MAX) begin
          w_hold_nxt = r_hold + CNT_W'(1);
        end
      end
      S_RELEASE: begin
`ifdef RST_SEQ_ACK_EN
        if (!r_rst[r_idx]) begin
          // Last stage already released; only its ack gates RUN.
          if (stage_ack[r_idx]) begin
            w_state_nxt = S_RUN;
          end else if (r_ack_cnt == c_ACK_LAST) begin
            w_abort_to = 1'b1;
          end else begin
            w_ack_cnt_nxt = r_ack_cnt + CNT_W'(1);
          end
        end else if (r_acked || stage_ack[w_prev_idx]) begin
          w_acked_nxt   = 1'b1;
          w_ack_cnt_nxt = '0;
          if (r_dly == c_DLY_LAST) begin
            w_rst_nxt[r_idx] = 1'b0;
            w_dly_nxt        = '0;
            w_acked_nxt      = 1'b0;
            if (r_idx == c_IDX_LAST) begin
              if (stage_ack[r_idx]) w_state_nxt = S_RUN;
            end else begin
              w_idx_nxt = r_idx + c_IDX_W'(1);
            end
          end else if (r_dly != c_CNT_MAX) begin
            w_dly_nxt = r_dly + CNT_W'(1);
          end
        end else if (r_ack_cnt == c_ACK_LAST) begin
          w_abort_to = 1'b1;
        end else begin
          w_ack_cnt_nxt = r_ack_cnt + CNT_W'(1);
        end
`else
        if (r_dly == c_DLY_LAST) begin
          w_rst_nxt[r_idx] = 1'b0;
          w_dly_nxt        = '0;
          if (r_idx == c_IDX_LAST) w_state_nxt = S_RUN;
          else                     w_idx_nxt   = r_idx + c_IDX_W'(1);
        end else if (r_dly != c_CNT_MAX) begin
          w_dly_nxt = r_dly + CNT_W'(1);
        end
`endif
      end
      S_RUN: begin
        w_rst_nxt = '0;
      end
      default: begin
        w_state_nxt = S_ASSERT;
        w_rst_nxt   = '1;
        w_hold_nxt  = '0;
      end
    endcase

    // A new request outranks any progress made above in RELEASE or RUN.
    if (r_state != S_ASSERT && w_req) begin
      w_state_nxt = S_ASSERT;
      w_rst_nxt   = '1;
      w_hold_nxt  = '0;
      w_dly_nxt   = '0;
      w_idx_nxt   = '0;
      if (!r_ext_s)       w_cause_nxt = 2'd1;
      else if (!r_lock_s) w_cause_nxt = 2'd2;
      else                w_cause_nxt = 2'd3;
    end
`ifdef RST_SEQ_ACK_EN
    else if (w_abort_to) begin
      w_state_nxt   = S_ASSERT;
      w_rst_nxt     = '1;
      w_hold_nxt    = '0;
      w_dly_nxt     = '0;
      w_idx_nxt     = '0;
      w_ack_cnt_nxt = '0;
      w_ack_to_nxt  = 1'b1;
    end
`endif
  end

  assign rst_out   = r_rst;
  assign seq_done  = (r_state == S_RUN);
  assign rst_cause = r_cause;
`ifdef RST_SEQ_ACK_EN
  assign ack_timeout = r_ack_to;
`endif

endmodule

`default_nettype wire

// File: tb/tb_reset_sequencer.sv
// ============================================================================
// Module   : tb_reset_sequencer
// Purpose  : Vector-table and sequence checks for reset_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       resetn;
  logic       ext_rst_n;
  logic       pll_locked;
  logic       sw_rst;
  logic [3:0] rst_out;
  logic       seq_done;
  logic [1:0] rst_cause;
`ifdef RST_SEQ_ACK_EN
  logic [3:0] stage_ack;
  logic       ack_timeout;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .N_STAGES   (4),
    .HOLD_CYCLES(16),
    .STAGE_DELAY(8),
    .CNT_W      (8)
`ifdef RST_SEQ_ACK_EN
    ,
    .ACK_TIMEOUT(20)
`endif
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .ext_rst_n  (ext_rst_n),
    .pll_locked (pll_locked),
    .sw_rst     (sw_rst),
`ifdef RST_SEQ_ACK_EN
    .stage_ack  (stage_ack),
    .ack_timeout(ack_timeout),
`endif
    .rst_out    (rst_out),
    .seq_done   (seq_done),
    .rst_cause  (rst_cause)
  );

  typedef struct {
    logic       ext;
    logic       lock;
    logic       sw;
    int         n;
    logic [3:0] rst;
    logic       done;
    logic [1:0] cause;
  } vec_t;

  typedef struct {
    logic [3:0] rst;
    logic       done;
    logic [1:0] cause;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  function automatic vec_t mk(input logic e, input logic l, input logic s, input int n,
                              input logic [3:0] r, input logic d, input logic [1:0] c);
    vec_t v;
    v.ext = e; v.lock = l; v.sw = s; v.n = n;
    v.rst = r; v.done = d; v.cause = c;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] r, input logic d, input logic [1:0] c);
    n_tests++;
    if (rst_out !== r || seq_done !== d || rst_cause !== c) begin
      n_fail++;
      $display("FAIL %s: rst_out=%b seq_done=%b rst_cause=%0d, expected rst_out=%b seq_done=%b rst_cause=%0d",
               tag, rst_out, seq_done, rst_cause, r, d, c);
    end
  endtask

  task automatic run_vec(input vec_t v, input int k);
    exp_t e;
    ext_rst_n  = v.ext;
    pll_locked = v.lock;
    sw_rst     = v.sw;
    sb.push_back('{rst: v.rst, done: v.done, cause: v.cause});
    repeat (v.n) tick();
    e = sb.pop_front();
    check($sformatf("vec%0d", k), e.rst, e.done, e.cause);
  endtask

  initial begin
    resetn     = 1'b0;
    ext_rst_n  = 1'b1;
    pll_locked = 1'b1;
    sw_rst     = 1'b0;
`ifdef RST_SEQ_ACK_EN
    stage_ack  = 4'b1111;
`endif

    // Edge counts: edge 0 is the first edge sampling resetn high.
    tbl.push_back(mk(1, 1, 0,  1, 4'b1111, 0, 0)); // edge 0
    tbl.push_back(mk(1, 1, 0, 25, 4'b1111, 0, 0)); // edge 25
    tbl.push_back(mk(1, 1, 0,  1, 4'b1110, 0, 0)); // edge 26
    tbl.push_back(mk(1, 1, 0,  7, 4'b1110, 0, 0)); // edge 33
    tbl.push_back(mk(1, 1, 0,  1, 4'b1100, 0, 0)); // edge 34
    tbl.push_back(mk(1, 1, 0,  8, 4'b1000, 0, 0)); // edge 42
    tbl.push_back(mk(1, 1, 0,  7, 4'b1000, 0, 0)); // edge 49
    tbl.push_back(mk(1, 1, 0,  1, 4'b0000, 1, 0)); // edge 50
    // Lock lost for one cycle, sampled at edge a.
    tbl.push_back(mk(1, 0, 0,  1, 4'b0000, 1, 0)); // a
    tbl.push_back(mk(1, 1, 0,  1, 4'b0000, 1, 0)); // a+1
    tbl.push_back(mk(1, 1, 0,  1, 4'b1111, 0, 2)); // a+2
    tbl.push_back(mk(1, 1, 0, 24, 4'b1111, 0, 2)); // a+26
    tbl.push_back(mk(1, 1, 0,  1, 4'b1110, 0, 2)); // a+27 (26 after lock returns)
    tbl.push_back(mk(1, 1, 0,  8, 4'b1100, 0, 2)); // a+35
    // Software reset mid-release.
    tbl.push_back(mk(1, 1, 1,  1, 4'b1111, 0, 3)); // s
    tbl.push_back(mk(1, 1, 0, 24, 4'b1111, 0, 3)); // s+24
    tbl.push_back(mk(1, 1, 0,  1, 4'b1110, 0, 3)); // s+25
    tbl.push_back(mk(1, 1, 0, 23, 4'b1000, 0, 3)); // s+48
    tbl.push_back(mk(1, 1, 0,  1, 4'b0000, 1, 3)); // s+49

    repeat (4) tick();
    check("in_reset", 4'b1111, 1'b0, 2'd0);
    resetn = 1'b1;

    foreach (tbl[k]) run_vec(tbl[k], k);

    // Synchronized ext request coincides with sw_rst: ext wins.
    ext_rst_n = 1'b0;
    tick();
    check("ext_sw_x", 4'b0000, 1'b1, 2'd3);
    tick();
    check("ext_sw_x1", 4'b0000, 1'b1, 2'd3);
    sw_rst = 1'b1;
    tick();
    check("ext_sw_prio", 4'b1111, 1'b0, 2'd1);
    sw_rst = 1'b0;

    // Repeated ext pulses keep the controller in ASSERT.
    for (int p = 0; p < 20; p++) begin
      ext_rst_n = 1'b0;
      tick();
      check($sformatf("pulse%0d_lo", p), 4'b1111, 1'b0, 2'd1);
      ext_rst_n = 1'b1;
      for (int q = 0; q < 9; q++) begin
        tick();
        check($sformatf("pulse%0d_hi%0d", p, q), 4'b1111, 1'b0, 2'd1);
      end
    end
    repeat (17) tick();
    check("post_pulse_hold", 4'b1111, 1'b0, 2'd1);
    tick();
    check("post_pulse_rel", 4'b1110, 1'b0, 2'd1);

`ifdef RST_SEQ_ACK_EN
    // Stage 1 never acknowledges: timeout 20 cycles after its release.
    stage_ack = 4'b1101;
    resetn    = 1'b0;
    repeat (2) tick();
    check("ack_rst", 4'b1111, 1'b0, 2'd0);
    n_tests++;
    if (ack_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_to_rst: ack_timeout=%b expected 0", ack_timeout);
    end
    resetn = 1'b1;
    repeat (27) tick();
    check("ack_s0", 4'b1110, 1'b0, 2'd0);
    repeat (8) tick();
    check("ack_s1", 4'b1100, 1'b0, 2'd0);
    repeat (19) tick();
    check("ack_wait", 4'b1100, 1'b0, 2'd0);
    n_tests++;
    if (ack_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_to_early: ack_timeout=%b expected 0", ack_timeout);
    end
    tick();
    check("ack_abort", 4'b1111, 1'b0, 2'd0);
    n_tests++;
    if (ack_timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL ack_to_set: ack_timeout=%b expected 1", ack_timeout);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
